// File: rtl/updown_mod_counter.sv
// Synchronous modulo-MOD up/down counter with parallel load, wrap or saturate
// at the range limits, a registered boundary pulse and limit decodes.
module updown_mod_counter #(
   parameter int unsigned     WIDTH    = 8,
   parameter longint unsigned MOD      = 256,
   parameter bit              SATURATE = 1'b0,
   parameter longint unsigned RST_VAL  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             ovf,
   output logic             at_max,
   output logic             at_zero
);

   // Reject illegal parameter combinations when the design is elaborated
   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("updown_mod_counter: WIDTH must be in 2..32");
   end
   if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
      $error("updown_mod_counter: MOD must be in 2..2**WIDTH");
   end
   if (RST_VAL >= MOD) begin : g_bad_rst_val
      $error("updown_mod_counter: RST_VAL must be below MOD");
   end

   // The modulus is held one bit wider than q so MOD = 2**WIDTH is representable
   localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MOD);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 64'd1);
   localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);

   logic [WIDTH-1:0] q_q, q_d;
   logic             ovf_q, ovf_d;
   logic             din_in_range;
   logic             q_is_max;
   logic             q_is_zero;

   assign din_in_range = ({1'b0, din} < MOD_W);
   assign q_is_max     = (q_q == MAX_VAL);
   assign q_is_zero    = (q_q == '0);

   always_comb begin
      q_d   = q_q;
      ovf_d = 1'b0;
      if (load) begin
         q_d = din_in_range ? din : MAX_VAL;
      end else if (en) begin
         if (up) begin
            if (q_is_max) begin
               ovf_d = 1'b1;
               if (!SATURATE) q_d = '0;
            end else begin
               q_d = q_q + 1'b1;
            end
         end else begin
            if (q_is_zero) begin
               ovf_d = 1'b1;
               if (!SATURATE) q_d = MAX_VAL;
            end else begin
               q_d = q_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q   <= RST_Q;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
      end
   end

   assign q       = q_q;
   assign ovf     = ovf_q;
   assign at_max  = q_is_max;
   assign at_zero = q_is_zero;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: wrap MOD=10, saturate MOD=10 and wrap MOD=16
// instances share one stimulus stream; expected results flow through a queue.
module tb_updown_mod_counter;

   logic       clk = 1'b0;
   logic       rst, en, up, load;
   logic [3:0] din;
   logic [3:0] q_w, q_s, q_p;
   logic       ovf_w, ovf_s, ovf_p;
   logic       amax_w, amax_s, amax_p;
   logic       azero_w, azero_s, azero_p;

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b0), .RST_VAL(0)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
      .q(q_w), .ovf(ovf_w), .at_max(amax_w), .at_zero(azero_w));
   updown_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b1), .RST_VAL(0)) u_sat (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
      .q(q_s), .ovf(ovf_s), .at_max(amax_s), .at_zero(azero_s));
   updown_mod_counter #(.WIDTH(4), .MOD(16), .SATURATE(1'b0), .RST_VAL(0)) u_pow2 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
      .q(q_p), .ovf(ovf_p), .at_max(amax_p), .at_zero(azero_p));

   typedef struct {
      int q[3];
      int ovf[3];
   } exp_t;

   exp_t exp_queue[$];
   int   model_q[3];
   int   mods[3] = '{10, 10, 16};
   bit   sats[3] = '{1'b0, 1'b1, 1'b0};
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input int obs, input int expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Behavioural reference: next count and boundary flag for one instance
   task automatic model_step(input int idx, input bit r, input bit ld, input int d,
                             input bit e, input bit u, output int ovf_o);
      int m;
      m     = mods[idx];
      ovf_o = 0;
      if (r) begin
         model_q[idx] = 0;
      end else if (ld) begin
         model_q[idx] = (d >= m) ? m - 1 : d;
      end else if (e) begin
         if (u && model_q[idx] == m - 1) begin
            ovf_o = 1;
            if (!sats[idx]) model_q[idx] = 0;
         end else if (!u && model_q[idx] == 0) begin
            ovf_o = 1;
            if (!sats[idx]) model_q[idx] = m - 1;
         end else begin
            model_q[idx] = u ? model_q[idx] + 1 : model_q[idx] - 1;
         end
      end
   endtask

   task automatic cycle(input bit r, input bit ld, input int d, input bit e, input bit u);
      exp_t ex;
      int   o;
      @(negedge clk);
      rst = r; load = ld; din = 4'(d); en = e; up = u;
      for (int i = 0; i < 3; i++) begin
         model_step(i, r, ld, d, e, u, o);
         ex.q[i]   = model_q[i];
         ex.ovf[i] = o;
      end
      exp_queue.push_back(ex);
      @(posedge clk);
      #1;
      ex = exp_queue.pop_front();
      chk("wrap_q", int'(q_w), ex.q[0]);
      chk("wrap_ovf", int'(ovf_w), ex.ovf[0]);
      chk("wrap_at_max", int'(amax_w), int'(ex.q[0] == 9));
      chk("wrap_at_zero", int'(azero_w), int'(ex.q[0] == 0));
      chk("sat_q", int'(q_s), ex.q[1]);
      chk("sat_ovf", int'(ovf_s), ex.ovf[1]);
      chk("sat_at_max", int'(amax_s), int'(ex.q[1] == 9));
      chk("sat_at_zero", int'(azero_s), int'(ex.q[1] == 0));
      chk("pow2_q", int'(q_p), ex.q[2]);
      chk("pow2_ovf", int'(ovf_p), ex.ovf[2]);
      chk("pow2_at_max", int'(amax_p), int'(ex.q[2] == 15));
      chk("pow2_at_zero", int'(azero_p), int'(ex.q[2] == 0));
      $display("[TB] rst=%0b load=%0b din=%0d en=%0b up=%0b | wrap q=%0d ovf=%0b | sat q=%0d ovf=%0b | pow2 q=%0d ovf=%0b",
               r, ld, d, e, u, q_w, ovf_w, q_s, ovf_s, q_p, ovf_p);
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; din = '0; en = 1'b0; up = 1'b1;
      foreach (model_q[i]) model_q[i] = 0;

      // Reset wins over a simultaneous load and step
      cycle(1, 1, 5, 1, 1);
      chk("reset_q", int'(q_w), 0);

      // Wrap-up: twelve increments
      for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 1);
      chk("wrap_up_end", int'(q_w), 2);
      chk("sat_up_end", int'(q_s), 9);

      // Wrap-down from reset
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 0);
      chk("wrap_down_end", int'(q_w), 8);

      // Saturate at top: load 8, four ups, then one down
      cycle(0, 1, 8, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1);
      chk("sat_hold_ovf", int'(ovf_s), 1);
      cycle(0, 0, 0, 1, 0);
      chk("sat_down_q", int'(q_s), 8);
      chk("sat_down_ovf", int'(ovf_s), 0);

      // Load beats enable; out-of-range load clamps
      cycle(0, 1, 5, 1, 1);
      chk("load_no_step", int'(q_w), 5);
      cycle(0, 1, 13, 0, 1);
      chk("load_clamp", int'(q_w), 9);

      // Boundary loads followed by boundary steps
      cycle(0, 1, 15, 0, 0);
      cycle(0, 0, 0, 1, 1);
      chk("pow2_wrap_up", int'(q_p), 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0);
      chk("pow2_wrap_down", int'(q_p), 15);

      // Alternate direction every cycle
      cycle(0, 1, 6, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, (i % 2) == 0);

      // Random enable and direction
      for (int i = 0; i < 24; i++) cycle(0, 0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

      // Reset mid-count while a step is pending
      cycle(0, 1, 7, 0, 0);
      cycle(1, 0, 0, 1, 1);
      chk("midrun_reset_q", int'(q_w), 0);
      chk("midrun_reset_ovf", int'(ovf_w), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
